// File: rtl/br_pkg.sv
// Shared types and widths for the branch resolve unit.
package br_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } br_funct3_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } br_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// PC redirect handshake between the branch resolve unit (master) and fetch (slave).
interface branch_resolve_unit_if;
   import br_pkg::*;

   logic            redir_valid;
   logic [XLEN-1:0] redir_pc;
   logic            redir_ready;

   modport master (output redir_valid, output redir_pc, input redir_ready);
   modport slave  (input redir_valid, input redir_pc, output redir_ready);
endinterface

// File: rtl/br_taken_decode.sv
// Combinational taken/not-taken decision and comparator mode select.
module br_taken_decode
   import br_pkg::*;
(
   input  logic       is_branch,
   input  logic       is_jal,
   input  logic       is_jalr,
   input  logic [2:0] funct3,
   input  logic       br_eq,
   input  logic       br_lt,
   output logic       br_un,
   output logic       taken_c,
   output logic       count_c
);

   logic one_flag_c;
   logic any_flag_c;
   logic f3_ok_c;
   logic cond_c;

   assign br_un      = funct3[1];
   assign any_flag_c = is_branch | is_jal | is_jalr;
   assign one_flag_c = (is_branch ^ is_jal ^ is_jalr) & ~(is_branch & is_jal & is_jalr);

   always_comb begin
      cond_c  = 1'b0;
      f3_ok_c = 1'b1;
      case (funct3)
         BEQ:         cond_c = br_eq;
         BNE:         cond_c = ~br_eq;
         BLT, BLTU:   cond_c = br_lt;
         BGE, BGEU:   cond_c = ~br_lt;
         default:     f3_ok_c = 1'b0;
      endcase
   end

   // Conflicting flags still count as a resolve, but never redirect.
   always_comb begin
      taken_c = 1'b0;
      count_c = any_flag_c;
      if (one_flag_c) begin
         if (is_branch) begin
            taken_c = cond_c & f3_ok_c;
            count_c = f3_ok_c;
         end else begin
            taken_c = 1'b1;
         end
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves control-flow instructions in EX, issues PC redirects to fetch and flushes IF/ID.
module branch_resolve_unit
   import br_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ex_valid,
   input  logic                   ex_is_branch,
   input  logic                   ex_is_jal,
   input  logic                   ex_is_jalr,
   input  logic [2:0]             ex_funct3,
   input  logic [XLEN-1:0]        ex_pc,
   input  logic [XLEN-1:0]        ex_imm,
   input  logic [XLEN-1:0]        ex_rs1,
   output logic                   br_un,
   input  logic                   br_eq,
   input  logic                   br_lt,
   output logic                   ex_stall,
   branch_resolve_unit_if.master  redir,
   output logic                   flush,
   output logic                   misalign,
   output logic [CNT_W-1:0]       cnt_branch,
   output logic [CNT_W-1:0]       cnt_taken
);

   localparam int unsigned FCW     = 4;
   localparam int unsigned FC_INIT = (FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1;

   br_state_e        state_q, state_d;
   logic [FCW-1:0]   fcnt_q, fcnt_d;
   logic [XLEN-1:0]  redir_pc_q, redir_pc_d;
   logic             misalign_q, misalign_d;
   logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
   logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;

   logic             taken_c;
   logic             count_c;
   logic             resolve_c;
   logic [XLEN-1:0]  sum_c;
   logic [XLEN-1:0]  target_c;

   br_taken_decode u_decode (
      .is_branch (ex_is_branch),
      .is_jal    (ex_is_jal),
      .is_jalr   (ex_is_jalr),
      .funct3    (ex_funct3),
      .br_eq     (br_eq),
      .br_lt     (br_lt),
      .br_un     (br_un),
      .taken_c   (taken_c),
      .count_c   (count_c)
   );

   assign resolve_c = (state_q == IDLE) && ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr);
   assign sum_c     = (ex_is_jalr ? ex_rs1 : ex_pc) + ex_imm;
   assign target_c  = ex_is_jalr ? (sum_c & ~XLEN'(1)) : sum_c;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         fcnt_q       <= '0;
         redir_pc_q   <= '0;
         misalign_q   <= 1'b0;
         cnt_branch_q <= '0;
         cnt_taken_q  <= '0;
      end else begin
         state_q      <= state_d;
         fcnt_q       <= fcnt_d;
         redir_pc_q   <= redir_pc_d;
         misalign_q   <= misalign_d;
         cnt_branch_q <= cnt_branch_d;
         cnt_taken_q  <= cnt_taken_d;
      end
   end

   // Next state, redirect target, flush countdown and saturating statistics.
   always_comb begin
      state_d      = state_q;
      fcnt_d       = fcnt_q;
      redir_pc_d   = redir_pc_q;
      misalign_d   = 1'b0;
      cnt_branch_d = cnt_branch_q;
      cnt_taken_d  = cnt_taken_q;

      if (resolve_c && count_c && (cnt_branch_q != '1)) cnt_branch_d = cnt_branch_q + CNT_W'(1);
      if (resolve_c && taken_c && (cnt_taken_q != '1))  cnt_taken_d  = cnt_taken_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            if (resolve_c && taken_c) begin
               if (target_c[1]) begin
                  misalign_d = 1'b1;
               end else begin
                  redir_pc_d = target_c;
                  state_d    = REDIRECT;
               end
            end
         end
         REDIRECT: begin
            if (redir.redir_ready) begin
               fcnt_d  = FCW'(FC_INIT);
               state_d = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
            end
         end
         FLUSH: begin
            if (fcnt_q == '0) state_d = IDLE;
            else              fcnt_d  = fcnt_q - FCW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      redir.redir_valid = 1'b0;
      flush             = 1'b0;
      ex_stall          = 1'b0;
      if (state_q != IDLE) begin
         flush    = 1'b1;
         ex_stall = 1'b1;
      end
      if (state_q == REDIRECT) redir.redir_valid = 1'b1;
   end

   assign redir.redir_pc = redir_pc_q;
   assign misalign       = misalign_q;
   assign cnt_branch     = cnt_branch_q;
   assign cnt_taken      = cnt_taken_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a redirect-target scoreboard.
module tb_branch_resolve_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_valid2;
   logic        ex_is_branch, ex_is_jal, ex_is_jalr;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_pc, ex_imm, ex_rs1;
   logic        br_eq, br_lt;

   logic        br_un, ex_stall, flush, misalign;
   logic [15:0] cnt_branch, cnt_taken;
   logic        br_un2, ex_stall2, flush2, misalign2;
   logic [1:0]  cnt_branch2, cnt_taken2;

   branch_resolve_unit_if ifc ();
   branch_resolve_unit_if ifc2 ();

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_pc;

   always #5 clk = ~clk;

   branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
      .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
      .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
      .br_un(br_un), .br_eq(br_eq), .br_lt(br_lt), .ex_stall(ex_stall),
      .redir(ifc), .flush(flush), .misalign(misalign),
      .cnt_branch(cnt_branch), .cnt_taken(cnt_taken)
   );

   branch_resolve_unit #(.FLUSH_CYCLES(0), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid2),
      .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
      .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
      .br_un(br_un2), .br_eq(br_eq), .br_lt(br_lt), .ex_stall(ex_stall2),
      .redir(ifc2), .flush(flush2), .misalign(misalign2),
      .cnt_branch(cnt_branch2), .cnt_taken(cnt_taken2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic v, input logic b, input logic j, input logic jr,
                        input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1, input logic eq, input logic lt);
      ex_valid = v; ex_is_branch = b; ex_is_jal = j; ex_is_jalr = jr;
      ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; br_eq = eq; br_lt = lt;
   endtask

   // Hold off fetch for `hold` cycles, accept, then wait for the unit to return to IDLE.
   task automatic accept_redirect(input int hold, input string tag);
      int i;
      logic [31:0] e;
      ex_valid = 1'b0;
      i = 0;
      while (!ifc.redir_valid && i < 20) begin step(); i++; end
      chk({tag, "_valid"}, 32'(ifc.redir_valid), 32'd1);
      e = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      chk({tag, "_pc"}, ifc.redir_pc, e);
      for (int k = 0; k < hold; k++) begin
         step();
         chk({tag, "_hold_valid"}, 32'(ifc.redir_valid), 32'd1);
         chk({tag, "_hold_pc"}, ifc.redir_pc, e);
         chk({tag, "_hold_stall"}, 32'(ex_stall), 32'd1);
      end
      ifc.redir_ready = 1'b1;
      step();
      ifc.redir_ready = 1'b0;
      i = 0;
      while (ex_stall && i < 10) begin step(); i++; end
      chk({tag, "_idle"}, 32'(ex_stall), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      ex_valid2 = 1'b0;
      ifc.redir_ready  = 1'b0;
      ifc2.redir_ready = 1'b1;
      drive(0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 32'h0, 0, 0);
      repeat (2) step();
      chk("rst_valid", 32'(ifc.redir_valid), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_stall", 32'(ex_stall), 32'd0);
      chk("rst_pc", ifc.redir_pc, 32'd0);
      chk("rst_cnt_branch", 32'(cnt_branch), 32'd0);
      chk("rst_cnt_taken", 32'(cnt_taken), 32'd0);
      rst_n = 1'b1;
      step();

      // BEQ taken: one redirect cycle followed by two flush cycles
      drive(1, 1, 0, 0, 3'b000, 32'h100, 32'h20, 32'h0, 1, 0);
      #1;
      chk("beq_br_un", 32'(br_un), 32'd0);
      sb.push_back(32'h120);
      step();
      ex_valid = 1'b0;
      chk("beq_valid", 32'(ifc.redir_valid), 32'd1);
      chk("beq_stall", 32'(ex_stall), 32'd1);
      chk("beq_flush0", 32'(flush), 32'd1);
      exp_pc = sb.pop_front();
      chk("beq_pc", ifc.redir_pc, exp_pc);
      ifc.redir_ready = 1'b1;
      step();
      ifc.redir_ready = 1'b0;
      chk("beq_valid_drop", 32'(ifc.redir_valid), 32'd0);
      chk("beq_flush1", 32'(flush), 32'd1);
      step();
      chk("beq_flush2", 32'(flush), 32'd1);
      step();
      chk("beq_flush_end", 32'(flush), 32'd0);
      chk("beq_stall_end", 32'(ex_stall), 32'd0);
      chk("beq_cnt_branch", 32'(cnt_branch), 32'd1);
      chk("beq_cnt_taken", 32'(cnt_taken), 32'd1);

      // comparator mode select
      drive(0, 1, 0, 0, 3'b110, 32'h0, 32'h0, 32'h0, 0, 0);
      #1;
      chk("bltu_br_un", 32'(br_un), 32'd1);
      ex_funct3 = 3'b100;
      #1;
      chk("blt_br_un", 32'(br_un), 32'd0);
      step();

      // BGE with lt=1 is not taken but still counted
      drive(1, 1, 0, 0, 3'b101, 32'h300, 32'h40, 32'h0, 0, 1);
      step();
      ex_valid = 1'b0;
      chk("bge_valid", 32'(ifc.redir_valid), 32'd0);
      chk("bge_stall", 32'(ex_stall), 32'd0);
      chk("bge_cnt_branch", 32'(cnt_branch), 32'd2);
      chk("bge_cnt_taken", 32'(cnt_taken), 32'd1);

      // JALR clears bit 0 of the target
      drive(1, 0, 0, 1, 3'b000, 32'h500, 32'h4, 32'h1001, 0, 0);
      sb.push_back(32'h1004);
      step();
      accept_redirect(0, "jalr");

      // JAL wraps modulo 2^32; fetch stalls the handshake for 5 cycles
      drive(1, 0, 1, 0, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'h0, 0, 0);
      sb.push_back(32'h10);
      step();
      accept_redirect(5, "jal");
      chk("jal_cnt_branch", 32'(cnt_branch), 32'd4);
      chk("jal_cnt_taken", 32'(cnt_taken), 32'd3);

      // misaligned target: one-cycle pulse, no redirect
      drive(1, 1, 0, 0, 3'b001, 32'h100, 32'h2, 32'h0, 0, 0);
      step();
      ex_valid = 1'b0;
      chk("mis_pulse", 32'(misalign), 32'd1);
      chk("mis_valid", 32'(ifc.redir_valid), 32'd0);
      chk("mis_stall", 32'(ex_stall), 32'd0);
      step();
      chk("mis_pulse_end", 32'(misalign), 32'd0);
      chk("mis_valid_after", 32'(ifc.redir_valid), 32'd0);

      // reserved funct3 is neither taken nor counted
      drive(1, 1, 0, 0, 3'b010, 32'h100, 32'h20, 32'h0, 1, 1);
      step();
      ex_valid = 1'b0;
      chk("f3_010_valid", 32'(ifc.redir_valid), 32'd0);
      chk("f3_010_cnt_branch", 32'(cnt_branch), 32'd5);

      // conflicting flags: counted, not taken
      drive(1, 1, 1, 0, 3'b000, 32'h100, 32'h20, 32'h0, 1, 0);
      step();
      ex_valid = 1'b0;
      chk("multi_valid", 32'(ifc.redir_valid), 32'd0);
      chk("multi_cnt_branch", 32'(cnt_branch), 32'd6);
      chk("multi_cnt_taken", 32'(cnt_taken), 32'd4);

      // reset in REDIRECT aborts the redirect
      drive(1, 1, 0, 0, 3'b000, 32'h200, 32'h40, 32'h0, 1, 0);
      step();
      ex_valid = 1'b0;
      chk("abort_pre_valid", 32'(ifc.redir_valid), 32'd1);
      rst_n = 1'b0;
      step();
      chk("abort_valid", 32'(ifc.redir_valid), 32'd0);
      chk("abort_flush", 32'(flush), 32'd0);
      chk("abort_stall", 32'(ex_stall), 32'd0);
      chk("abort_pc", ifc.redir_pc, 32'd0);
      chk("abort_cnt_branch", 32'(cnt_branch), 32'd0);
      rst_n = 1'b1;
      step();
      chk("abort_stays_idle", 32'(ifc.redir_valid), 32'd0);

      // FLUSH_CYCLES=0, CNT_W=2: back to IDLE right after accept, counters stop at 3
      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 1, 0, 3'b000, 32'(k) * 32'h100, 32'h10, 32'h0, 0, 0);
         ex_valid2 = 1'b1;
         sb.push_back(32'(k) * 32'h100 + 32'h10);
         step();
         ex_valid2 = 1'b0;
         chk("fc0_valid", 32'(ifc2.redir_valid), 32'd1);
         exp_pc = sb.pop_front();
         chk("fc0_pc", ifc2.redir_pc, exp_pc);
         step();
         chk("fc0_idle_stall", 32'(ex_stall2), 32'd0);
         chk("fc0_idle_flush", 32'(flush2), 32'd0);
         chk("fc0_cnt_taken", 32'(cnt_taken2), (k >= 2) ? 32'd3 : 32'(k + 1));
      end
      chk("sat_cnt_branch", 32'(cnt_branch2), 32'd3);
      chk("sat_cnt_taken", 32'(cnt_taken2), 32'd3);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
